// File: rtl/mem_resp_pkg.sv
// Shared definitions for the CPU memory-bus responder: IO window layout,
// status-byte bit positions and the registered read-source selector.
package mem_resp_pkg;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [2:0]  IO_DATA = 3'd0;
  localparam logic [2:0]  IO_STAT = 3'd4;

  localparam int STAT_TX_FULL_BIT = 0;
  localparam int STAT_RX_FULL_BIT = 1;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_RX   = 2'd2,
    SRC_STAT = 2'd3
  } rd_src_e;

  function automatic logic [7:0] stat_byte(input logic rx_full, input logic tx_full);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_RX_FULL_BIT] = rx_full;
    s[STAT_TX_FULL_BIT] = tx_full;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with power-of-two depth; pushes when full and
// pops when empty are dropped.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers are exactly AW bits wide, so they wrap mod DEPTH on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory side of the CPU byte bus: byte RAM plus an IO window (TX FIFO, RX
// holding reg, status, halt). MEM_RESP_STATS_EN builds read/write counters.
module mem_bus_responder
  import mem_resp_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        rdy_out,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready,
  output logic        sim_done,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [7:0] ram [2**RAM_AW];

  rd_src_e     src_q, src_d;
  logic [7:0]  ram_rd_q, ram_rd_d;
  logic [7:0]  io_rd_q, io_rd_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_full_q, rx_full_d;
  logic        rdy_q, rdy_d;
  logic        alive_q;
  logic        sim_done_q, sim_done_d;

  logic              is_io, rd_acc, wr_acc;
  logic [2:0]        io_off;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_word;
  logic              ram_we, tx_push, tx_pop, halt, rx_pop, rx_load;
  logic [CW-1:0]     tx_count, tx_count_next;
  logic              tx_full, tx_empty;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^cpu_a[31:18];

  // A request is only honoured on an edge where rdy_out was already high.
  assign is_io    = cpu_a[17];
  assign io_off   = cpu_a[2:0];
  assign ram_addr = cpu_a[RAM_AW-1:0];
  assign rd_acc   = rdy_q & ~cpu_wr;
  assign wr_acc   = rdy_q & cpu_wr;
  assign ram_we   = wr_acc & ~is_io;
  assign tx_push  = wr_acc & is_io & (io_off == IO_DATA);
  assign halt     = wr_acc & is_io & (io_off == IO_STAT);
  assign rx_pop   = rd_acc & is_io & (io_off == IO_DATA);
  assign rx_load  = io_rx_valid & io_rx_ready;
  assign tx_pop   = io_tx_valid & io_tx_ready;
  assign ram_word = ram[ram_addr];

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (cpu_dout),
    .pop       (tx_pop),
    .head      (io_tx_data),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  always_comb begin
    src_d      = src_q;
    ram_rd_d   = ram_rd_q;
    io_rd_d    = io_rd_q;
    rx_data_d  = rx_data_q;
    rx_full_d  = rx_full_q;
    sim_done_d = sim_done_q | halt;

    if (rd_acc) begin
      if (!is_io) begin
        src_d    = SRC_RAM;
        ram_rd_d = ram_word;
      end else if (io_off == IO_DATA) begin
        src_d   = SRC_RX;
        io_rd_d = rx_full_q ? rx_data_q : 8'h00;
      end else if (io_off == IO_STAT) begin
        src_d   = SRC_STAT;
        io_rd_d = stat_byte(rx_full_q, tx_full);
      end else begin
        src_d = SRC_ZERO;
      end
    end else if (ram_we) begin
      src_d    = SRC_RAM;
      ram_rd_d = cpu_dout;
    end

    // A load can only coincide with a pop when the reg was empty; the load wins.
    if (rx_pop)  rx_full_d = 1'b0;
    if (rx_load) begin
      rx_full_d = 1'b1;
      rx_data_d = io_rx_data;
    end

    // Keeping two free slots guarantees any write accepted next edge fits.
    tx_count_next = tx_count + CW'(tx_push) - CW'(tx_pop);
    rdy_d         = (tx_count_next <= CW'(TX_DEPTH - 2));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      src_q      <= SRC_ZERO;
      ram_rd_q   <= 8'h00;
      io_rd_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_full_q  <= 1'b0;
      rdy_q      <= 1'b0;
      alive_q    <= 1'b0;
      sim_done_q <= 1'b0;
    end else begin
      src_q      <= src_d;
      ram_rd_q   <= ram_rd_d;
      io_rd_q    <= io_rd_d;
      rx_data_q  <= rx_data_d;
      rx_full_q  <= rx_full_d;
      rdy_q      <= rdy_d;
      alive_q    <= 1'b1;
      sim_done_q <= sim_done_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= cpu_dout;
  end

  always_comb begin
    case (src_q)
      SRC_RAM:           cpu_din = ram_rd_q;
      SRC_RX, SRC_STAT:  cpu_din = io_rd_q;
      default:           cpu_din = 8'h00;
    endcase
  end

  assign rdy_out     = rdy_q;
  assign io_tx_valid = ~tx_empty;
  assign io_rx_ready = alive_q & ~rx_full_q;
  assign sim_done    = sim_done_q;

`ifdef MEM_RESP_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q + 32'(rd_acc);
    wr_cnt_d = wr_cnt_q + 32'(wr_acc);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign stat_rd_cnt = rd_cnt_q;
  assign stat_wr_cnt = wr_cnt_q;
`else
  assign stat_rd_cnt = 32'h0;
  assign stat_wr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder: RAM, TX FIFO, RX reg,
// status, halt, reset and the optional MEM_RESP_STATS_EN counters.
module tb_mem_bus_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] cpu_a = 32'h30001;
  logic        cpu_wr = 1'b1;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic        rdy_out;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready = 1'b0;
  logic [7:0]  io_rx_data = 8'h00;
  logic        io_rx_valid = 1'b0;
  logic        io_rx_ready;
  logic        sim_done;
  logic [31:0] stat_rd_cnt;
  logic [31:0] stat_wr_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  mem_bus_responder dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .cpu_a       (cpu_a),
    .cpu_wr      (cpu_wr),
    .cpu_dout    (cpu_dout),
    .cpu_din     (cpu_din),
    .rdy_out     (rdy_out),
    .io_tx_data  (io_tx_data),
    .io_tx_valid (io_tx_valid),
    .io_tx_ready (io_tx_ready),
    .io_rx_data  (io_rx_data),
    .io_rx_valid (io_rx_valid),
    .io_rx_ready (io_rx_ready),
    .sim_done    (sim_done),
    .stat_rd_cnt (stat_rd_cnt),
    .stat_wr_cnt (stat_wr_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents one request, checks any TX byte leaving on
  // the coming edge, and returns at the following negedge.
  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_a    = a;
    cpu_wr   = wr;
    cpu_dout = d;
    if (io_tx_valid && io_tx_ready) begin
      if (tx_q.size() > 0) chk("tx_order", {24'h0, io_tx_data}, {24'h0, tx_q.pop_front()});
      else                 chk("tx_spurious_valid", {31'h0, io_tx_valid}, 32'h0);
    end
    @(negedge clk_in);
  endtask

  task automatic idle();
    drive(32'h30001, 1'b1, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e, input string tag);
    exp_q.push_back(e);
    drive(a, 1'b0, 8'h00);
    chk(tag, {24'h0, cpu_din}, {24'h0, exp_q.pop_front()});
  endtask

  task automatic tx_wr(input logic [7:0] d);
    tx_q.push_back(d);
    drive(32'h30000, 1'b1, d);
  endtask

  task automatic do_reset();
    rst_in      = 1'b0;
    cpu_a       = 32'h30001;
    cpu_wr      = 1'b1;
    cpu_dout    = 8'h00;
    io_tx_ready = 1'b0;
    io_rx_valid = 1'b0;
    io_rx_data  = 8'h00;
    tx_q.delete();
    #1;
    chk("rst_cpu_din", {24'h0, cpu_din}, 32'h0);
    chk("rst_rdy", {31'h0, rdy_out}, 32'h0);
    chk("rst_tx_valid", {31'h0, io_tx_valid}, 32'h0);
    chk("rst_rx_ready", {31'h0, io_rx_ready}, 32'h0);
    chk("rst_sim_done", {31'h0, sim_done}, 32'h0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("rel_rdy", {31'h0, rdy_out}, 32'h1);
    chk("rel_rx_ready", {31'h0, io_rx_ready}, 32'h1);
    chk("rel_cpu_din", {24'h0, cpu_din}, 32'h0);
    chk("rel_tx_empty", {31'h0, io_tx_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] exp_rd_cnt;
    logic [31:0] exp_wr_cnt;
    #2;
    do_reset();

    // RAM write-first and one-cycle read latency
    drive(32'h00010, 1'b1, 8'hA5);
    chk("ram_wr_first", {24'h0, cpu_din}, 32'hA5);
    drive(32'h00011, 1'b1, 8'h3C);
    chk("ram_wr_first2", {24'h0, cpu_din}, 32'h3C);
    rd(32'h00010, 8'hA5, "ram_rd_lat1");
    idle();
    chk("ram_rd_hold", {24'h0, cpu_din}, 32'hA5);
    rd(32'h00011, 8'h3C, "ram_rd2");

    // TX fill with sink stalled: rdy falls after the 7th byte
    io_tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tx_wr(8'h41 + 8'(i));
      if (i == 5) chk("rdy_after_6", {31'h0, rdy_out}, 32'h1);
    end
    chk("rdy_fall_7", {31'h0, rdy_out}, 32'h0);
    drive(32'h30000, 1'b1, 8'h99);
    drive(32'h00010, 1'b1, 8'h77);
    drive(32'h30004, 1'b1, 8'h00);
    chk("halt_ignored_stalled", {31'h0, sim_done}, 32'h0);
    chk("rdy_still_low", {31'h0, rdy_out}, 32'h0);
    io_tx_ready = 1'b1;
    repeat (9) idle();
    chk("tx_drained", tx_q.size(), 32'h0);
    chk("tx_valid_empty", {31'h0, io_tx_valid}, 32'h0);
    chk("rdy_back", {31'h0, rdy_out}, 32'h1);
    rd(32'h00010, 8'hA5, "ram_ignored_wr");

    // RX holding register and status
    io_rx_data  = 8'h5A;
    io_rx_valid = 1'b1;
    idle();
    io_rx_valid = 1'b0;
    io_rx_data  = 8'h00;
    chk("rx_ready_full", {31'h0, io_rx_ready}, 32'h0);
    rd(32'h30004, 8'h02, "stat_rx_full");
    rd(32'h30000, 8'h5A, "rx_pop");
    rd(32'h30004, 8'h00, "stat_after_pop");
    rd(32'h30000, 8'h00, "rx_empty_read");
    chk("rx_ready_empty", {31'h0, io_rx_ready}, 32'h1);
    io_rx_data  = 8'h66;
    io_rx_valid = 1'b1;
    rd(32'h30000, 8'h00, "rx_pop_load_same");
    io_rx_valid = 1'b0;
    rd(32'h30004, 8'h02, "stat_load_wins");
    rd(32'h30000, 8'h66, "rx_after_load");
    rd(32'h30002, 8'h00, "io_other_off");

    // Push+pop at count 3, then prove count by where rdy falls
    io_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) tx_wr(8'hB0 + 8'(i));
    io_tx_ready = 1'b1;
    for (int i = 3; i < 9; i++) begin
      tx_wr(8'hB0 + 8'(i));
      chk("rdy_push_pop", {31'h0, rdy_out}, 32'h1);
    end
    io_tx_ready = 1'b0;
    for (int i = 9; i < 13; i++) begin
      tx_wr(8'hB0 + 8'(i));
      if (i == 11) chk("rdy_count6", {31'h0, rdy_out}, 32'h1);
    end
    chk("rdy_count7", {31'h0, rdy_out}, 32'h0);
    io_tx_ready = 1'b1;
    repeat (9) idle();
    chk("tx_wrap_drained", tx_q.size(), 32'h0);
    chk("tx_wrap_valid", {31'h0, io_tx_valid}, 32'h0);

    // Halt is sticky; IO writes leave cpu_din alone
    rd(32'h00011, 8'h3C, "ram_rd_pre_halt");
    drive(32'h30004, 1'b1, 8'hFF);
    chk("sim_done_set", {31'h0, sim_done}, 32'h1);
    chk("io_wr_keeps_din", {24'h0, cpu_din}, 32'h3C);
    idle();
    idle();
    chk("sim_done_sticky", {31'h0, sim_done}, 32'h1);

    // Reset in the middle of a read with bytes queued
    drive(32'h00012, 1'b1, 8'h5C);
    io_tx_ready = 1'b0;
    tx_wr(8'hC1);
    tx_wr(8'hC2);
    chk("pre_rst_din", {24'h0, cpu_din}, 32'h5C);
    cpu_a  = 32'h00012;
    cpu_wr = 1'b0;
    #3;
    do_reset();

    // Counters: exactly 3 reads and 2 writes after reset
    rd(32'h00012, 8'h5C, "ram_kept_after_rst");
    rd(32'h00010, 8'hA5, "ram_kept_after_rst2");
    drive(32'h00013, 1'b1, 8'h11);
    rd(32'h00013, 8'h11, "ram_rd_new");
    drive(32'h30001, 1'b1, 8'h00);
`ifdef MEM_RESP_STATS_EN
    exp_rd_cnt = 32'd3;
    exp_wr_cnt = 32'd2;
`else
    exp_rd_cnt = 32'd0;
    exp_wr_cnt = 32'd0;
`endif
    chk("stat_rd_cnt", stat_rd_cnt, exp_rd_cnt);
    chk("stat_wr_cnt", stat_wr_cnt, exp_wr_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
